// File: rtl/retro_catc_multi.sv
// Multi-channel cycle-accurate timing control.
// Each channel produces a core clock-enable from a programmable divide of Clk.
// Nominal ticks swallowed by Delay become debt, which is repaid at the faster
// catch-up divide, so the long-run tick count tracks the nominal rate.
module retro_catc_multi #(
  parameter int Channels       = 2,
  parameter int DivWidth       = 8,
  parameter int DebtWidth      = 16,
  parameter int DefaultDiv     = 9,
  parameter int DefaultFastDiv = 4
) (
  input  logic                                               Clk,
  input  logic                                               ResetN,
  input  logic                                               ClkEn,
  input  logic [Channels-1:0]                                Delay,
  input  logic                                               CfgWe,
  input  logic [((Channels > 1) ? $clog2(Channels) : 1)-1:0] CfgChan,
  input  logic [DivWidth-1:0]                                CfgDiv,
  input  logic [DivWidth-1:0]                                CfgFastDiv,
  output logic [Channels-1:0]                                ClkEnOut,
  output logic [Channels-1:0]                                Behind,
  output logic [Channels-1:0]                                Overrun,
  output logic [DebtWidth-1:0]                               DebtRd
);

  localparam int ChanW = (Channels > 1) ? $clog2(Channels) : 1;
  localparam logic [ChanW:0] ChanLimit = (ChanW + 1)'(Channels);

  logic [DivWidth-1:0]  div_q      [Channels];
  logic [DivWidth-1:0]  div_d      [Channels];
  logic [DivWidth-1:0]  fdiv_q     [Channels];
  logic [DivWidth-1:0]  fdiv_d     [Channels];
  logic [DivWidth-1:0]  nom_cnt_q  [Channels];
  logic [DivWidth-1:0]  nom_cnt_d  [Channels];
  logic [DivWidth-1:0]  fast_cnt_q [Channels];
  logic [DivWidth-1:0]  fast_cnt_d [Channels];
  logic [DebtWidth-1:0] debt_q     [Channels];
  logic [DebtWidth-1:0] debt_d     [Channels];
  logic [Channels-1:0]  ovr_q;
  logic [Channels-1:0]  ovr_d;

  logic [DivWidth-1:0]  ediv       [Channels];
  logic [DivWidth-1:0]  efast      [Channels];
  logic [Channels-1:0]  nom_tick;
  logic [Channels-1:0]  fast_tick;
  logic [Channels-1:0]  ce;
  logic [Channels-1:0]  cfg_hit;
  logic                 chan_ok;

  assign chan_ok = ({1'b0, CfgChan} < ChanLimit);

  // Effective divides, tick decode and the per-channel clock enable
  always_comb begin
    for (int unsigned i = 0; i < Channels; i++) begin
      ediv[i]  = (div_q[i] == '0) ? DivWidth'(1) : div_q[i];
      efast[i] = (fdiv_q[i] == '0) ? DivWidth'(1) : fdiv_q[i];
      if (efast[i] > ediv[i]) efast[i] = ediv[i];
      nom_tick[i]  = (nom_cnt_q[i] == ediv[i] - 1'b1);
      fast_tick[i] = (fast_cnt_q[i] == efast[i] - 1'b1);
      // ResetN gating forces the enable low the instant reset asserts
      ce[i] = ResetN & ClkEn & ~Delay[i] &
              ((debt_q[i] != '0) ? fast_tick[i] : nom_tick[i]);
      cfg_hit[i] = CfgWe & chan_ok & (CfgChan == ChanW'(i));
    end
  end

  // Next-state for counters, debt and configuration
  always_comb begin
    for (int unsigned i = 0; i < Channels; i++) begin
      div_d[i]      = div_q[i];
      fdiv_d[i]     = fdiv_q[i];
      nom_cnt_d[i]  = nom_cnt_q[i];
      fast_cnt_d[i] = fast_cnt_q[i];
      debt_d[i]     = debt_q[i];
      ovr_d[i]      = ovr_q[i];
      if (ClkEn) begin
        nom_cnt_d[i]  = nom_tick[i] ? '0 : nom_cnt_q[i] + 1'b1;
        fast_cnt_d[i] = (Delay[i] | ce[i] | fast_tick[i]) ? '0 : fast_cnt_q[i] + 1'b1;
        // Net change is NomTick - ClkEnOut; +1 at the ceiling flags overrun instead
        if (nom_tick[i] && !ce[i]) begin
          if (debt_q[i] == '1) ovr_d[i] = 1'b1;
          else                 debt_d[i] = debt_q[i] + 1'b1;
        end else if (ce[i] && !nom_tick[i]) begin
          debt_d[i] = debt_q[i] - 1'b1;
        end
        // Config write overrides the counter/overrun updates but leaves debt alone
        if (cfg_hit[i]) begin
          div_d[i]      = CfgDiv;
          fdiv_d[i]     = CfgFastDiv;
          nom_cnt_d[i]  = '0;
          fast_cnt_d[i] = '0;
          ovr_d[i]      = 1'b0;
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < Channels; i++) begin
        div_q[i]      <= DivWidth'(DefaultDiv);
        fdiv_q[i]     <= DivWidth'(DefaultFastDiv);
        nom_cnt_q[i]  <= '0;
        fast_cnt_q[i] <= '0;
        debt_q[i]     <= '0;
      end
      ovr_q <= '0;
    end else begin
      for (int unsigned i = 0; i < Channels; i++) begin
        div_q[i]      <= div_d[i];
        fdiv_q[i]     <= fdiv_d[i];
        nom_cnt_q[i]  <= nom_cnt_d[i];
        fast_cnt_q[i] <= fast_cnt_d[i];
        debt_q[i]     <= debt_d[i];
      end
      ovr_q <= ovr_d;
    end
  end

  // Output decode and debt read-back
  always_comb begin
    ClkEnOut = ce;
    Overrun  = ovr_q;
    for (int unsigned i = 0; i < Channels; i++) Behind[i] = (debt_q[i] != '0);
    DebtRd = chan_ok ? debt_q[CfgChan] : '0;
  end

endmodule
